// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size/state encodings and the access-legality check for the data-memory LSU
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    // True for the illegal size code or any access not aligned to its own size
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'b11) || (size == SZ_H && off[0]) || (size == SZ_W && off != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_align.sv
// dmem_align: little-endian lane extract/extend for loads and lane merge for sub-word stores
module dmem_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  off,
    input  logic [31:0] rd_word,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] mask;
    logic [31:0] wrep;

    // Load lane select/extend; store data is replicated across lanes and masked into the old word
    always_comb begin
        b       = 8'(rd_word >> {off, 3'b000});
        h       = off[1] ? rd_word[31:16] : rd_word[15:0];
        ld_data = size == SZ_B ? {{24{~uns & b[7]}}, b} :
                  size == SZ_H ? {{16{~uns & h[15]}}, h} : rd_word;
        mask    = size == SZ_B ? 32'h0000_00FF << {off, 3'b000} :
                  size == SZ_H ? (off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : 32'hFFFF_FFFF;
        wrep    = size == SZ_B ? {4{wdata[7:0]}} :
                  size == SZ_H ? {2{wdata[15:0]}} : wdata;
        st_word = (old_word & ~mask) | (wrep & mask);
    end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding load/store front end for a word-wide SRAM with read-modify-write for sub-word stores
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data
);

    state_t                state, state_n;
    logic                  we_q, uns_q, err_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q, old_q, rdata_q, ld_data, st_word;
    logic                  accept;

    assign accept      = state == IDLE && req_valid;
    assign mem_rd_addr = addr_q[ADDR_WIDTH+1:2];
    assign mem_wr_addr = addr_q[ADDR_WIDTH+1:2];
    assign mem_wr_data = st_word;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;

    dmem_align u_align (
        .size     (size_q),
        .uns      (uns_q),
        .off      (addr_q[1:0]),
        .rd_word  (mem_rd_data),
        .old_word (old_q),
        .wdata    (wdata_q),
        .ld_data  (ld_data),
        .st_word  (st_word)
    );

    // State register; reset drops the SRAM enables immediately since they decode from state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next state and handshake/enable decode
    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_n = misaligned(req_size, req_addr[1:0]) ? RESP :
                              (!req_we || req_size != SZ_W) ? READ : WRITE;
            end
            READ: begin
                mem_rd_en = 1'b1;
                state_n   = we_q ? WRITE : RESP;
            end
            WRITE: begin
                mem_wr_en = 1'b1;
                state_n   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request capture, load result and old-word registers; response data is cleared at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            err_q   <= misaligned(req_size, req_addr[1:0]);
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
        end else if (state == READ) begin
            if (we_q) old_q   <= mem_rd_data;
            else      rdata_q <= ld_data;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed self-checking bench for dmem_lsu with a behavioural SRAM
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [12:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_rd_en;
    logic [10:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        mem_wr_en;
    logic [10:0] mem_wr_addr;
    logic [31:0] mem_wr_data;

    logic [31:0] mem [0:2047];
    logic        poke_en = 1'b0;
    logic [10:0] poke_addr = '0;
    logic [31:0] poke_data = '0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    logic [10:0] last_wa = '0;
    logic [31:0] last_wd = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data)
    );

    assign mem_rd_data = mem_rd_en ? mem[mem_rd_addr] : 32'h0;

    // SRAM write port plus bench-side preload, and access bookkeeping
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        if (mem_wr_en) begin
            mem[mem_wr_addr] <= mem_wr_data;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= mem_wr_addr;
            last_wd <= mem_wr_data;
        end
        if (mem_rd_en) rd_cnt <= rd_cnt + 1;
        if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [10:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic run(input logic we, input logic [1:0] sz, input logic uns, input logic [12:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        err = rsp_err;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          rc, wc;

        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
        chk("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
        chk("rst_wr_data", mem_wr_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        poke(11'd4, 32'h0);
        poke(11'd5, 32'h0);

        run(1'b1, 2'b10, 1'b0, 13'h010, 32'hDEADBEEF, rd, err, lat);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_wa", 32'(last_wa), 32'd4);
        chk("sw_wd", last_wd, 32'hDEADBEEF);
        chk("sw_err", 32'(err), 32'd0);
        chk("sw_rdata", rd, 32'h0);

        run(1'b0, 2'b10, 1'b0, 13'h010, 32'h0, rd, err, lat);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", 32'(err), 32'd0);
        chk("lw_lat", 32'(lat), 32'd2);

        poke(11'd4, 32'h11223344);
        rc = rd_cnt; wc = wr_cnt;
        run(1'b1, 2'b00, 1'b0, 13'h012, 32'h123456AA, rd, err, lat);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_reads", 32'(rd_cnt - rc), 32'd1);
        chk("sb_writes", 32'(wr_cnt - wc), 32'd1);
        chk("sb_wd", last_wd, 32'h11AA3344);
        run(1'b0, 2'b00, 1'b0, 13'h012, 32'h0, rd, err, lat);
        chk("lb_rdata", rd, 32'hFFFFFFAA);
        run(1'b0, 2'b00, 1'b1, 13'h012, 32'h0, rd, err, lat);
        chk("lbu_rdata", rd, 32'h000000AA);
        run(1'b0, 2'b00, 1'b0, 13'h010, 32'h0, rd, err, lat);
        chk("lb0_rdata", rd, 32'h00000044);

        run(1'b1, 2'b01, 1'b0, 13'h016, 32'hFFFF8001, rd, err, lat);
        chk("sh_wa", 32'(last_wa), 32'd5);
        chk("sh_wd", last_wd, 32'h80010000);
        run(1'b0, 2'b01, 1'b0, 13'h016, 32'h0, rd, err, lat);
        chk("lh_rdata", rd, 32'hFFFF8001);
        run(1'b0, 2'b01, 1'b1, 13'h016, 32'h0, rd, err, lat);
        chk("lhu_rdata", rd, 32'h00008001);

        rc = rd_cnt; wc = wr_cnt;
        run(1'b0, 2'b10, 1'b0, 13'h011, 32'h0, rd, err, lat);
        chk("lw_mis_err", 32'(err), 32'd1);
        chk("lw_mis_rdata", rd, 32'h0);
        chk("lw_mis_lat", 32'(lat), 32'd1);
        run(1'b1, 2'b01, 1'b0, 13'h013, 32'h5555, rd, err, lat);
        chk("sh_mis_err", 32'(err), 32'd1);
        chk("sh_mis_lat", 32'(lat), 32'd1);
        run(1'b0, 2'b11, 1'b0, 13'h010, 32'h0, rd, err, lat);
        chk("sz11_err", 32'(err), 32'd1);
        chk("sz11_rdata", rd, 32'h0);
        chk("err_no_reads", 32'(rd_cnt - rc), 32'd0);
        chk("err_no_writes", 32'(wr_cnt - wc), 32'd0);

        poke(11'd4, 32'hCAFE12EF);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 13'h010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_valid0", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        req_valid = 1'b1; req_size = 2'b00; req_unsigned = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, 32'hCAFE12EF);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_valid", 32'(rsp_valid), 32'd0);
        chk("bp_hs_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_acc_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("bp2_valid", 32'(rsp_valid), 32'd1);
        chk("bp2_rdata", rsp_rdata, 32'h000000EF);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        wc = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 13'h010; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_rd_en", 32'(mem_rd_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_wr_en", 32'(mem_wr_en), 32'd0);
        chk("mid_rd_en_off", 32'(mem_rd_en), 32'd0);
        chk("mid_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rsp_rdata", rsp_rdata, 32'h0);
        chk("mid_wr_data", mem_wr_data, 32'h0);
        chk("mid_wr_addr", 32'(mem_wr_addr), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_no_write", 32'(wr_cnt - wc), 32'd0);
        run(1'b0, 2'b10, 1'b0, 13'h010, 32'h0, rd, err, lat);
        chk("mid_lw_rdata", rd, 32'hCAFE12EF);

        chk("never_both_en", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
